// File: rtl/btn_debounce.sv
// Push-button conditioner: multi-flop synchroniser, then a counter-qualified debounce FSM
// producing a clean pressed level plus one-cycle press/release pulses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_REL   | button accepted as released
// S_CHK_P | candidate press, counting consecutive pressed samples
// S_PRS   | button accepted as pressed
// S_CHK_R | candidate release, counting consecutive released samples
module btn_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_btn,
   output logic o_rise,
   output logic o_fall,
   output logic o_busy
);

   localparam int   CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic REL_LVL = (ACTIVE_LOW != 0);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_REL   = 2'd0,
      S_CHK_P = 2'd1,
      S_PRS   = 2'd2,
      S_CHK_R = 2'd3
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   p;

   // Only sync[0] ever samples the raw pin; the chain resets to the released level
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync <= {SYNC_STAGES{REL_LVL}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], i_btn};
      end
   end

   assign p = sync[SYNC_STAGES-1] ^ REL_LVL;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= S_REL;
         cnt    <= '0;
         o_btn  <= 1'b0;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
         o_busy <= 1'b0;
      end else begin
         o_rise <= 1'b0;
         o_fall <= 1'b0;
         case (state)
            S_REL: begin
               if (p) begin
                  state  <= S_CHK_P;
                  cnt    <= CNT_ONE;
                  o_busy <= 1'b1;
               end
            end
            S_CHK_P: begin
               if (!p) begin
                  state  <= S_REL;
                  cnt    <= '0;
                  o_busy <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state  <= S_PRS;
                  cnt    <= '0;
                  o_btn  <= 1'b1;
                  o_rise <= 1'b1;
                  o_busy <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_PRS: begin
               if (!p) begin
                  state  <= S_CHK_R;
                  cnt    <= CNT_ONE;
                  o_busy <= 1'b1;
               end
            end
            S_CHK_R: begin
               if (p) begin
                  state  <= S_PRS;
                  cnt    <= '0;
                  o_busy <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state  <= S_REL;
                  cnt    <= '0;
                  o_btn  <= 1'b0;
                  o_fall <= 1'b1;
                  o_busy <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= S_REL;
               cnt    <= '0;
               o_btn  <= 1'b0;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Output vector order is {o_btn, o_rise, o_fall, o_busy}.
module tb_btn_debounce;

   logic i_clk;
   logic i_rst_n;
   logic i_btn;
   logic o_btn;
   logic o_rise;
   logic o_fall;
   logic o_busy;

   int checks;
   int errors;

   btn_debounce #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .ACTIVE_LOW     (1)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_btn  (i_btn),
      .o_btn  (o_btn),
      .o_rise (o_rise),
      .o_fall (o_fall),
      .o_busy (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input int n, input logic [3:0] obs,
                        input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%b expected=%b", tag, n, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] e;
      checks  = 0;
      errors  = 0;
      i_btn   = 1'b1;
      i_rst_n = 1'b0;
      #1;
      check("in_reset", 0, {o_btn, o_rise, o_fall, o_busy}, 4'b0000);
      step();
      step();
      i_rst_n = 1'b1;

      // released and idle: nothing moves
      for (int n = 1; n <= 20; n++) begin
         step();
         check("idle", n, {o_btn, o_rise, o_fall, o_busy}, 4'b0000);
      end

      // clean press: busy on cycles 3..5, level and pulse on cycle 6
      i_btn = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         step();
         e[3] = (n >= 6);
         e[2] = (n == 6);
         e[1] = 1'b0;
         e[0] = (n >= 3 && n <= 5);
         check("press", n, {o_btn, o_rise, o_fall, o_busy}, e);
      end

      // bounce while pressed: level held, no release pulse
      i_btn = 1'b1; step();
      check("bounce_btn", 1, {o_btn, o_rise, o_fall}, 3'b100);
      i_btn = 1'b0; step();
      check("bounce_btn", 2, {o_btn, o_rise, o_fall}, 3'b100);
      i_btn = 1'b1; step();
      check("bounce_btn", 3, {o_btn, o_rise, o_fall}, 3'b100);
      i_btn = 1'b0;
      for (int n = 4; n <= 12; n++) begin
         step();
         check("bounce_btn", n, {o_btn, o_rise, o_fall}, 3'b100);
      end
      check("bounce_settled", 0, {o_btn, o_rise, o_fall, o_busy}, 4'b1000);

      // release glitch of 3 samples: bounce on the last count sample still rejects
      i_btn = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         if (n == 3) i_btn = 1'b0;
         e = {1'b1, 1'b0, 1'b0, (n >= 3 && n <= 5)};
         check("rel_glitch", n, {o_btn, o_rise, o_fall, o_busy}, e);
      end

      // clean release: busy 3..5, fall pulse and level drop on cycle 6
      i_btn = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         e[3] = (n < 6);
         e[2] = 1'b0;
         e[1] = (n == 6);
         e[0] = (n >= 3 && n <= 5);
         check("release", n, {o_btn, o_rise, o_fall, o_busy}, e);
      end

      // reset mid-qualification drops the candidate
      i_btn = 1'b0;
      step(); step(); step();
      check("chk_p_before_rst", 3, {o_btn, o_rise, o_fall, o_busy}, 4'b0001);
      #2 i_rst_n = 1'b0;
      #1;
      check("async_rst_chk_p", 0, {o_btn, o_rise, o_fall, o_busy}, 4'b0000);
      step();
      check("held_rst", 0, {o_btn, o_rise, o_fall, o_busy}, 4'b0000);
      i_rst_n = 1'b1;

      // pressed through reset release: rise 6 cycles after release
      for (int n = 1; n <= 6; n++) begin
         step();
         e[3] = (n >= 6);
         e[2] = (n == 6);
         e[1] = 1'b0;
         e[0] = (n >= 3 && n <= 5);
         check("press_after_rst", n, {o_btn, o_rise, o_fall, o_busy}, e);
      end

      // reset while o_rise is high clears it at once
      #2 i_rst_n = 1'b0;
      #1;
      check("async_rst_rise", 0, {o_btn, o_rise, o_fall, o_busy}, 4'b0000);
      step();
      i_rst_n = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         step();
         e[3] = (n >= 6);
         e[2] = (n == 6);
         e[1] = 1'b0;
         e[0] = (n >= 3 && n <= 5);
         check("press_after_rst2", n, {o_btn, o_rise, o_fall, o_busy}, e);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
